// File: rtl/return_stack_if.sv
// Request/response bundle between the CPU control path and the return-address stack.
// The master drives push/pop requests; the slave reports top-of-stack, occupancy and fault flags.
interface return_stack_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  clear_err;
    logic [ADDR_WIDTH-1:0] top_addr;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push,
        output pop,
        output push_addr,
        output clear_err,
        input  top_addr,
        input  count,
        input  empty,
        input  full,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  push,
        input  pop,
        input  push_addr,
        input  clear_err,
        output top_addr,
        output count,
        output empty,
        output full,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/return_stack.sv
// Return-address stack with a combinational top-of-stack read so RET completes in one cycle.
// Define RETURN_STACK_WRAP_EN to let a push while full overwrite the oldest entry instead of dropping it.
module return_stack #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 8
) (
    input logic           clk,
    input logic           reset,
    return_stack_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0]      sp_q;
    logic [PTR_W-1:0]      sp_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;

    logic                  wrEn;
    logic [PTR_W-1:0]      wrIdx;
    logic [PTR_W-1:0]      topIdx;
    logic                  isEmpty;
    logic                  isFull;
    logic                  newOverflow;
    logic                  newUnderflow;

    // sp points at the next free slot, so the live top sits one below it (modulo DEPTH).
    assign topIdx  = sp_q - PTR_W'(1);
    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == FULL_COUNT);

    always_comb begin
        sp_d         = sp_q;
        count_d      = count_q;
        wrEn         = 1'b0;
        wrIdx        = sp_q;
        newOverflow  = 1'b0;
        newUnderflow = 1'b0;

        if (bus.push && bus.pop && !isEmpty) begin
            wrEn  = 1'b1;
            wrIdx = topIdx;
        end else if (bus.push) begin
            if (!isFull) begin
                wrEn    = 1'b1;
                sp_d    = sp_q + PTR_W'(1);
                count_d = count_q + CNT_W'(1);
            end else begin
                newOverflow = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
                // Slot sp holds the oldest entry when full, so writing it keeps the newest DEPTH addresses.
                wrEn = 1'b1;
                sp_d = sp_q + PTR_W'(1);
`endif
            end
        end else if (bus.pop) begin
            if (!isEmpty) begin
                sp_d    = topIdx;
                count_d = count_q - CNT_W'(1);
            end else begin
                newUnderflow = 1'b1;
            end
        end

        // A fault raised in the same cycle as clear_err must survive the clear.
        overflow_d  = newOverflow  | (overflow_q  & ~bus.clear_err);
        underflow_d = newUnderflow | (underflow_q & ~bus.clear_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wrEn) begin
            storage_q[wrIdx] <= bus.push_addr;
        end
    end

    assign bus.top_addr  = isEmpty ? '0 : storage_q[topIdx];
    assign bus.count     = count_q;
    assign bus.empty     = isEmpty;
    assign bus.full      = isFull;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: a queue-based stack model predicts every cycle's outputs,
// and a negedge monitor pops those predictions and compares them with the DUT.
module tb_return_stack;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        int            stepId;
        logic [AW-1:0] top;
        logic [CW-1:0] count;
        logic          empty;
        logic          full;
        logic          overflow;
        logic          underflow;
    } expT;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    return_stack_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) rsIf ();

    return_stack #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rsIf.slave)
    );

    expT expQ[$];
    int  totalCount = 0;
    int  badCount   = 0;
    int  stepNo     = 0;

    // Reference model: back of the queue is the top of stack, front is the oldest entry.
    int  modelQ[$];
    bit  modelOvf = 1'b0;
    bit  modelUnf = 1'b0;

    task automatic checkOutput(input string name, input int stepId,
                               input logic [31:0] actual, input logic [31:0] required);
        totalCount++;
        if (actual !== required) begin
            badCount++;
            $display("[TB] FAIL %s step=%0d actual=0x%0h required=0x%0h", name, stepId, actual, required);
        end
    endtask

    always @(negedge clk) begin
        expT e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("top_addr",  e.stepId, 32'(rsIf.top_addr),  32'(e.top));
            checkOutput("count",     e.stepId, 32'(rsIf.count),     32'(e.count));
            checkOutput("empty",     e.stepId, 32'(rsIf.empty),     32'(e.empty));
            checkOutput("full",      e.stepId, 32'(rsIf.full),      32'(e.full));
            checkOutput("overflow",  e.stepId, 32'(rsIf.overflow),  32'(e.overflow));
            checkOutput("underflow", e.stepId, 32'(rsIf.underflow), 32'(e.underflow));
        end
    end

    task automatic applyStimulus(input bit rst, input bit doPush, input bit doPop,
                                 input logic [AW-1:0] addr, input bit clr);
        expT e;
        bit  newOvf;
        bit  newUnf;
        reset          = rst;
        rsIf.push      = doPush;
        rsIf.pop       = doPop;
        rsIf.push_addr = addr;
        rsIf.clear_err = clr;
        @(posedge clk);
        #1;
        newOvf = 1'b0;
        newUnf = 1'b0;
        if (rst) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            if (doPush && doPop && modelQ.size() > 0) begin
                modelQ[modelQ.size() - 1] = int'(addr);
            end else if (doPush) begin
                if (modelQ.size() < DEPTH) begin
                    modelQ.push_back(int'(addr));
                end else begin
                    newOvf = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
                    void'(modelQ.pop_front());
                    modelQ.push_back(int'(addr));
`endif
                end
            end else if (doPop) begin
                if (modelQ.size() > 0) void'(modelQ.pop_back());
                else newUnf = 1'b1;
            end
            modelOvf = newOvf || (modelOvf && !clr);
            modelUnf = newUnf || (modelUnf && !clr);
        end
        stepNo++;
        e.stepId    = stepNo;
        e.top       = (modelQ.size() > 0) ? AW'(modelQ[modelQ.size() - 1]) : '0;
        e.count     = CW'(modelQ.size());
        e.empty     = (modelQ.size() == 0);
        e.full      = (modelQ.size() == DEPTH);
        e.overflow  = modelOvf;
        e.underflow = modelUnf;
        expQ.push_back(e);
    endtask

    initial begin
        reset          = 1'b1;
        rsIf.push      = 1'b0;
        rsIf.pop       = 1'b0;
        rsIf.push_addr = '0;
        rsIf.clear_err = 1'b0;

        // Reset then idle.
        applyStimulus(1, 0, 0, 12'h000, 0);
        applyStimulus(0, 0, 0, 12'h000, 0);
        applyStimulus(0, 0, 0, 12'h000, 0);

        // Basic LIFO order.
        applyStimulus(0, 1, 0, 12'h010, 0);
        applyStimulus(0, 1, 0, 12'h020, 0);
        applyStimulus(0, 1, 0, 12'h030, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 12'h000, 0);

        // Fill, then push while full; pops reveal which entries survived.
        applyStimulus(0, 1, 0, 12'h111, 0);
        applyStimulus(0, 1, 0, 12'h222, 0);
        applyStimulus(0, 1, 0, 12'h333, 0);
        applyStimulus(0, 1, 0, 12'h444, 0);
        applyStimulus(0, 1, 0, 12'h555, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 12'h000, 0);
        applyStimulus(0, 0, 0, 12'h000, 1);

        // Underflow, clear, then clear racing a fresh underflow.
        applyStimulus(0, 0, 1, 12'h000, 0);
        applyStimulus(0, 0, 0, 12'h000, 1);
        applyStimulus(0, 0, 1, 12'h000, 1);
        applyStimulus(0, 0, 0, 12'h000, 1);

        // Push+pop replaces the top; on empty it acts as a plain push.
        applyStimulus(0, 1, 0, 12'h0A0, 0);
        applyStimulus(0, 1, 1, 12'h0B0, 0);
        applyStimulus(0, 0, 1, 12'h000, 0);
        applyStimulus(0, 1, 1, 12'h0F0, 0);
        applyStimulus(0, 0, 1, 12'h000, 0);

        // Reset beats a simultaneous push.
        applyStimulus(0, 1, 0, 12'h0C0, 0);
        applyStimulus(0, 1, 0, 12'h0D0, 0);
        applyStimulus(1, 1, 0, 12'h0E0, 0);
        applyStimulus(0, 0, 0, 12'h000, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          AW'($urandom),
                          $urandom_range(0, 9) == 0);
        end
        applyStimulus(0, 0, 0, 12'h000, 0);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (expQ.size() != 0) begin
            badCount++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the single-cycle CPU's subroutine mechanism. It stores the return PC on every JSB-driven `push` and supplies it for the RET-driven `pop`, which sets `pc_mux` to select the stack output. The block sits beside the program counter. Its top-of-stack output is combinational so RET completes in one cycle. It also tracks occupancy and reports overflow and underflow faults.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: width of a stored return address (PC width).
- `DEPTH`, 8: number of entries. Must be a power of two, at least 2.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `push`, input, 1: write `push_addr` as the new top on this edge.
- `pop`, input, 1: discard the top entry on this edge.
- `push_addr`, input, ADDR_WIDTH: return address to store (PC+1 from the datapath).
- `top_addr`, output, ADDR_WIDTH: combinational current top entry. It is 0 when empty.
- `count`, output, $clog2(DEPTH)+1: number of valid entries, from 0 to DEPTH.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.
- `overflow`, output, 1: sticky. Set by a push while full.
- `underflow`, output, 1: sticky. Set by a pop while empty.
- `clear_err`, input, 1: clears `overflow` and `underflow` on this edge.

## Operation
- State:
  - stack pointer `sp`: next free slot, 0 to DEPTH-1, wraps modulo DEPTH.
  - `count`.
  - sticky flags.
  - storage array of DEPTH x ADDR_WIDTH.
- `top_addr` = storage[sp-1 mod DEPTH] when `count != 0`, else 0. Purely combinational, with no dependence on `push` or `pop` in the same cycle.
- Push only, not full: storage[sp] <= push_addr; sp <= sp+1; count <= count+1.
- Pop only, not empty: sp <= sp-1; count <= count-1. Storage is untouched.
- Push and pop together, not empty: storage[sp-1] <= push_addr (top replaced); sp and count unchanged; no flag change.
- Push and pop together, empty: treated as push only. No underflow.
- Pop only, empty: state unchanged; underflow <= 1.
- Push only, full: overflow <= 1. Storage behaviour depends on the Configuration section.
- clear_err and a new fault in the same cycle: the new fault wins and the flag reads 1 afterward.
- Reset: sp=0, count=0, overflow=0, underflow=0. Storage is not cleared; because it is empty, top_addr reads 0.
- Reset in the same cycle as push or pop: reset wins and the request is discarded.

## Timing
- `top_addr` is valid in the same cycle the entry becomes top. A push on edge N is visible on `top_addr` right after edge N.
- Single-cycle RET: the controller asserts `pop` and selects `top_addr` into the PC in the same cycle. The pop retires on that same edge.
- Flags, `count`, `empty` and `full` update on the edge that causes the change and are registered-derived. The only combinational path is from the storage read to `top_addr`.
- Zero-cycle handshake: there is no ready/valid. Each request is accepted on the edge it is presented.

## Configuration
- `RETURN_STACK_WRAP_EN` defined, push while full:
  - overwrites the oldest entry (storage[sp] <= push_addr; sp <= sp+1);
  - count stays DEPTH;
  - overflow is set;
  - the most recent DEPTH return addresses remain correct.
- `RETURN_STACK_WRAP_EN` undefined, push while full:
  - the push is dropped;
  - storage, sp and count are unchanged;
  - overflow is set.

## Test plan
Run with DEPTH=4, ADDR_WIDTH=12.
- Reset, then idle -> count=0, empty=1, full=0, top_addr=0x000, both flags 0.
- Push 0x010, 0x020, 0x030 on consecutive cycles, then pop three times -> top_addr reads 0x030, 0x020, 0x010 in turn, then 0x000. empty=1 after the third pop, no flags set.
- Push 0x111 to 0x444 (full=1), then push 0x555:
  - overflow=1 in both builds;
  - without WRAP_EN, top=0x444 and four pops return 0x444, 0x333, 0x222, 0x111;
  - with WRAP_EN, four pops return 0x555, 0x444, 0x333, 0x222.
- Pop on empty -> underflow=1, count=0. Then assert clear_err -> underflow=0 next cycle. Then assert clear_err together with a pop on empty -> underflow stays 1.
- Push 0x0A0, then push 0x0B0 and pop in the same cycle -> count=1, top_addr=0x0B0. With push and pop together on empty -> count=1, top=push_addr, underflow=0.
- Push 0x0C0 and 0x0D0, then assert reset together with push 0x0E0 -> next cycle count=0, top_addr=0x000; the push is discarded and flags are 0.
